ngs_boot_core_gpio_ec: RTL and testbench
========================================

Name: ngs_boot_core_gpio_ec

Overview:
Parametrised Avalon-MM bidirectional GPIO with per-bit edge capture, input synchronisation, and atomic set/clear of the output register.
Successor to the boot-core fixed 30-bit GPIO. Adds:
- configurable width
- metastability-safe input sampling
- rising/falling/level interrupt sources
- write-1-to-clear capture register
Sits on the boot-core peripheral bus; drives one shared irq line to the CPU.

Parameters:
WIDTH, 30, number of GPIO pins (1..32).
SYNC_STAGES, 2, input synchroniser depth (2 or 3).
RESET_DIR, 0, reset value of the direction register (WIDTH bits, 1 = output).
RESET_OUT, 0, reset value of the output data register (WIDTH bits).

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-high reset.
address  in  3  word address of the register.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe.
writedata  in  32  write data; bits above WIDTH-1 are ignored.
readdata  out  32  registered read data.
irq  out  1  level interrupt to the CPU.
bidir_port  inout  WIDTH  pins; bit i is driven with data_out[i] when dir[i]=1, otherwise Z.

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high; it is applied to every flop.
- Register map (address : read / write):
  - 0: sync_in / data_out.
  - 1: dir / dir.
  - 2: irq_mask / irq_mask.
  - 3: edge_cap / write-1-to-clear.
  - 4: data_out / data_out |= wd.
  - 5: data_out / data_out &= ~wd.
  - 6: rise_en / rise_en.
  - 7: fall_en / fall_en.
- Write strobe: wr = chipselect & ~write_n. Register updates take effect on the clock edge of wr; the new value is visible at the pins the next cycle.
- Read path: readdata is re-registered every cycle from the address mux, independent of chipselect. One-cycle latency. Bits 31..WIDTH read 0.
- Input sampling: sync_in = bidir_port passed through SYNC_STAGES flops. prev holds sync_in delayed one more cycle.
- Capture source per bit i:
  - rise_en=1, fall_en=0: sync_in & ~prev.
  - rise_en=0, fall_en=1: ~sync_in & prev.
  - both 1: sync_in ^ prev.
  - both 0: level mode; the source is sync_in itself.
- edge_cap update: edge_cap <= (edge_cap & ~clr) | src, where clr = writedata when wr & address==3, else 0.
  - If a source event and a clear land on the same bit in the same cycle, set wins; no event is lost.
  - In level mode, a bit whose pin is still high re-sets on the cycle after it is cleared.
- irq = |(edge_cap & irq_mask), combinational from registers; no glitch paths from the pins.
- Arming after reset:
  - A counter of SYNC_STAGES+1 cycles runs after reset deassertion.
  - Until it expires, edge sources are forced to 0 and prev tracks sync_in.
  - Purpose: the flush of the synchroniser chain must not create spurious edges.
  - Level sources are also gated during this window.
- Reset values:
  - readdata 0, irq 0, edge_cap 0, irq_mask 0, rise_en 0, fall_en 0.
  - dir = RESET_DIR, data_out = RESET_OUT.
  - Synchroniser and prev are 0; the arm counter is 0 (disarmed).
- Reset asserted mid-operation: all state returns to reset values immediately, and pins float per RESET_DIR. After deassertion, the arming window repeats.
- Changing rise_en/fall_en does not clear edge_cap; software clears it explicitly.
- Read-back of an output pin: address 0 returns the synchronised pin value, not data_out. data_out is read at address 4/5.

Decomposition:
- Package ngs_boot_core_gpio_pkg holds the address constants ADDR_DATA..ADDR_FALL (0..7) and the WIDTH legality check function.
- One sub-module, ngs_boot_core_gpio_ec_sync. It takes a per-bus synchroniser chain plus prev, gated by the arm signal, and outputs sync_in and the rise/fall pulses. The top level holds the register file, the capture logic and the read mux.

Test Plan:
1. Reset check: pulse reset, then read all 8 addresses. readdata is 0 except address 1 = RESET_DIR and addresses 4/5 = RESET_OUT. irq=0 and the pins are Z.
2. Output set/clear: write dir=0x3FFFFFFF, addr0=0x0000000F, addr4=0x00000F00, addr5=0x00000003. Pins read 0x00000F0C at address 4. bidir_port reaches 0x00000F0C one cycle after the last write.
3. Rising capture: rise_en=0x1, irq_mask=0x1, dir=0, then drive pin0 0→1. edge_cap[0]=1 and irq rises exactly SYNC_STAGES+1 cycles after the pin edge. Then write addr3=0x1; edge_cap=0 and irq=0 the next cycle.
4. Falling and both-edge capture: fall_en=0x2, rise_en=0x4, fall_en|=0x4. Toggle pin1 and pin2. Pin1 captures only on 1→0; pin2 captures on both edges.
5. Clear/set collision: with edge_cap[0]=1, write addr3=0x1 in the same cycle a new rising edge reaches pin0's source. edge_cap[0] stays 1.
6. Level mode and arming: hold pin5=1 through reset deassertion with rise_en=fall_en=0. edge_cap[5] stays 0 for SYNC_STAGES+1 cycles, then becomes 1 and re-asserts the cycle after each addr3=0x20 clear while the pin stays high.

Source files
------------

// File: rtl/ngs_boot_core_gpio_pkg.sv
// ngs_boot_core_gpio_pkg: register addresses and parameter checks shared by the GPIO block
package ngs_boot_core_gpio_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;
    localparam logic [2:0] ADDR_RISE = 3'd6;
    localparam logic [2:0] ADDR_FALL = 3'd7;

    function automatic bit width_ok(input int w);
        return w >= 1 && w <= 32;
    endfunction

endpackage

// File: rtl/ngs_boot_core_gpio_ec_if.sv
// ngs_boot_core_gpio_ec_if: Avalon-MM slave bus and interrupt line of the GPIO block
interface ngs_boot_core_gpio_ec_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/ngs_boot_core_gpio_ec_sync.sv
// ngs_boot_core_gpio_ec_sync: pin synchroniser chain plus one-cycle history, edge pulses gated by arm
module ngs_boot_core_gpio_ec_sync #(
    parameter int WIDTH       = 30,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             armed,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q, chain_d;
    logic [WIDTH-1:0]                  prev_q, prev_d;

    assign sync_in = chain_q[SYNC_STAGES-1];
    assign rise    = {WIDTH{armed}} & sync_in & ~prev_q;
    assign fall    = {WIDTH{armed}} & ~sync_in & prev_q;

    // Shift pins through the chain; prev always follows sync_in so arming starts edge-free
    always_comb begin
        chain_d    = chain_q;
        chain_d[0] = pins;
        for (int k = 1; k < SYNC_STAGES; k++) chain_d[k] = chain_q[k-1];
        prev_d     = sync_in;
    end

    // Synchroniser and history flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
            prev_q  <= '0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

endmodule

// File: rtl/ngs_boot_core_gpio_ec.sv
// ngs_boot_core_gpio_ec: Avalon-MM GPIO with synchronised inputs, edge capture and atomic set/clear
module ngs_boot_core_gpio_ec
    import ngs_boot_core_gpio_pkg::*;
#(
    parameter int               WIDTH       = 30,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    ngs_boot_core_gpio_ec_if.slave bus,
    inout  wire  [WIDTH-1:0]       bidir_port
);

    localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [2:0]       arm_cnt_q, arm_cnt_d;
    logic             armed, wr;
    logic [WIDTH-1:0] wd, clr, src, rd_sel;
    logic [WIDTH-1:0] sync_in, rise, fall;
    logic             unused_wd;

    if (!width_ok(WIDTH) || SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_param
        $error("ngs_boot_core_gpio_ec: WIDTH must be 1..32 and SYNC_STAGES 2 or 3");
    end

    ngs_boot_core_gpio_ec_sync #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .armed  (armed),
        .pins   (bidir_port),
        .sync_in(sync_in),
        .rise   (rise),
        .fall   (fall)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign bidir_port[i] = dir_q[i] ? data_out_q[i] : 1'bz;
    end

    assign armed        = arm_cnt_q == ARM_CYCLES;
    assign bus.readdata = readdata_q;
    assign bus.irq      = |(edge_cap_q & irq_mask_q);
    assign unused_wd    = ^bus.writedata;

    // Bus decode, register updates, capture sources (set beats clear) and read mux
    always_comb begin
        wr         = bus.chipselect & ~bus.write_n;
        wd         = bus.writedata[WIDTH-1:0];
        dir_d      = (wr && bus.address == ADDR_DIR)  ? wd : dir_q;
        irq_mask_d = (wr && bus.address == ADDR_MASK) ? wd : irq_mask_q;
        rise_en_d  = (wr && bus.address == ADDR_RISE) ? wd : rise_en_q;
        fall_en_d  = (wr && bus.address == ADDR_FALL) ? wd : fall_en_q;
        data_out_d = !wr                      ? data_out_q :
                     bus.address == ADDR_DATA ? wd :
                     bus.address == ADDR_SET  ? data_out_q | wd :
                     bus.address == ADDR_CLR  ? data_out_q & ~wd : data_out_q;
        clr        = (wr && bus.address == ADDR_EDGE) ? wd : '0;
        src        = (rise_en_q & ~fall_en_q & rise) |
                     (~rise_en_q & fall_en_q & fall) |
                     (rise_en_q & fall_en_q & (rise | fall)) |
                     (~rise_en_q & ~fall_en_q & sync_in & {WIDTH{armed}});
        edge_cap_d = (edge_cap_q & ~clr) | src;
        arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + 3'd1;
        rd_sel     = bus.address == ADDR_DATA ? sync_in :
                     bus.address == ADDR_DIR  ? dir_q :
                     bus.address == ADDR_MASK ? irq_mask_q :
                     bus.address == ADDR_EDGE ? edge_cap_q :
                     bus.address == ADDR_RISE ? rise_en_q :
                     bus.address == ADDR_FALL ? fall_en_q : data_out_q;
        readdata_d = 32'(rd_sel);
    end

    // Register file, capture register, arm counter and registered read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q      <= RESET_DIR;
            data_out_q <= RESET_OUT;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            readdata_q <= '0;
            arm_cnt_q  <= '0;
        end else begin
            dir_q      <= dir_d;
            data_out_q <= data_out_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            readdata_q <= readdata_d;
            arm_cnt_q  <= arm_cnt_d;
        end
    end

endmodule

// File: tb/tb_ngs_boot_core_gpio_ec.sv
// tb_ngs_boot_core_gpio_ec: directed and random stimulus checked against a pin-history model
module tb_ngs_boot_core_gpio_ec;

    localparam int           W    = 30;
    localparam int           S    = 2;
    localparam logic [W-1:0] RDIR = 30'h3000_0000;
    localparam logic [W-1:0] ROUT = 30'h2000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ngs_boot_core_gpio_ec_if bus();
    wire  [W-1:0] pins;
    logic [W-1:0] tb_val;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: register values plus a history of pin values, newest first
    logic [W-1:0] m_dir, m_out, m_mask, m_ec, m_rise, m_fall;
    logic [31:0]  m_rd;
    logic [W-1:0] hist [0:3];
    int           m_k;
    logic [W-1:0] m_p, m_s, m_pr, m_src, m_clr, m_wd, m_out_n;
    logic [31:0]  m_rd_n;
    logic         m_wr, m_armed, m_irq;

    for (genvar i = 0; i < W; i++) begin : g_drv
        assign pins[i] = m_dir[i] ? 1'bz : tb_val[i];
    end

    ngs_boot_core_gpio_ec #(
        .WIDTH      (W),
        .SYNC_STAGES(S),
        .RESET_DIR  (RDIR),
        .RESET_OUT  (ROUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .bidir_port(pins)
    );

    // what the next clock edge must do, from the register-map and capture rules
    always_comb begin
        m_p     = (m_dir & m_out) | (~m_dir & tb_val);
        m_s     = hist[S-1];
        m_pr    = hist[S];
        m_armed = m_k >= S + 1;
        m_wr    = bus.chipselect && !bus.write_n;
        m_wd    = bus.writedata[W-1:0];
        m_clr   = (m_wr && bus.address == 3'd3) ? m_wd : '0;
        m_irq   = |(m_ec & m_mask);
        m_src   = '0;
        for (int i = 0; i < W; i++)
            if (m_armed)
                m_src[i] = (m_rise[i] && m_fall[i]) ? m_s[i] ^ m_pr[i] :
                           m_rise[i] ? m_s[i] & ~m_pr[i] :
                           m_fall[i] ? ~m_s[i] & m_pr[i] : m_s[i];
        m_out_n = m_out;
        if (m_wr && bus.address == 3'd0) m_out_n = m_wd;
        if (m_wr && bus.address == 3'd4) m_out_n = m_out | m_wd;
        if (m_wr && bus.address == 3'd5) m_out_n = m_out & ~m_wd;
        case (bus.address)
            3'd0:    m_rd_n = 32'(m_s);
            3'd1:    m_rd_n = 32'(m_dir);
            3'd2:    m_rd_n = 32'(m_mask);
            3'd3:    m_rd_n = 32'(m_ec);
            3'd6:    m_rd_n = 32'(m_rise);
            3'd7:    m_rd_n = 32'(m_fall);
            default: m_rd_n = 32'(m_out);
        endcase
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_dir  <= RDIR;
            m_out  <= ROUT;
            m_mask <= '0;
            m_ec   <= '0;
            m_rise <= '0;
            m_fall <= '0;
            m_rd   <= '0;
            m_k    <= 0;
            for (int j = 0; j < 4; j++) hist[j] <= '0;
        end else begin
            m_rd  <= m_rd_n;
            m_out <= m_out_n;
            if (m_wr && bus.address == 3'd1) m_dir  <= m_wd;
            if (m_wr && bus.address == 3'd2) m_mask <= m_wd;
            if (m_wr && bus.address == 3'd6) m_rise <= m_wd;
            if (m_wr && bus.address == 3'd7) m_fall <= m_wd;
            m_ec <= (m_ec & ~m_clr) | m_src;
            for (int j = 3; j > 0; j--) hist[j] <= hist[j-1];
            hist[0] <= m_p;
            if (m_k < 1000) m_k <= m_k + 1;
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("readdata", bus.readdata, m_rd);
        chk("irq", 32'(bus.irq), 32'(m_irq));
        chk("pins", 32'(pins), 32'(m_p));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        bus.address = a;
        tick();
        v = bus.readdata;
    endtask

    initial begin
        logic [31:0] v;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = '0;
        bus.writedata  = '0;
        tb_val         = '0;
        idle(3);
        reset = 1'b0;
        // reset values
        rd(3, v); chk("rst_edge", v, 32'h0);
        rd(0, v); chk("rst_sync", v, 32'h0);
        rd(1, v); chk("rst_dir", v, 32'h3000_0000);
        rd(2, v); chk("rst_mask", v, 32'h0);
        rd(4, v); chk("rst_out4", v, 32'h2000_0000);
        rd(5, v); chk("rst_out5", v, 32'h2000_0000);
        rd(6, v); chk("rst_rise", v, 32'h0);
        rd(7, v); chk("rst_fall", v, 32'h0);
        chk("rst_irq", 32'(bus.irq), 32'h0);
        rd(0, v); chk("rst_pin29", v, 32'h2000_0000);
        rd(3, v); chk("rst_lvl29", v, 32'h2000_0000);
        // output set/clear
        wr(1, 32'h3FFF_FFFF);
        wr(0, 32'h0000_000F);
        wr(4, 32'h0000_0F00);
        wr(5, 32'h0000_0003);
        chk("setclr_pins", 32'(pins), 32'h0000_0F0C);
        rd(4, v); chk("setclr_rd4", v, 32'h0000_0F0C);
        wr(1, 32'h0);
        idle(S + 3);
        wr(3, 32'hFFFF_FFFF);
        // rising capture and its latency
        wr(6, 32'h1);
        wr(2, 32'h1);
        tb_val[0] = 1'b1;
        for (int c = 1; c <= S + 1; c++) begin
            tick();
            chk("rise_lat", 32'(bus.irq), (c == S + 1) ? 32'h1 : 32'h0);
        end
        rd(3, v); chk("rise_cap", v, 32'h1);
        wr(3, 32'h1);
        chk("rise_clr_irq", 32'(bus.irq), 32'h0);
        rd(3, v); chk("rise_clr", v, 32'h0);
        // falling-only on pin1, both edges on pin2
        wr(7, 32'h2);
        wr(6, 32'h5);
        wr(7, 32'h6);
        tb_val[2:1] = 2'b11;
        idle(S + 2);
        rd(3, v); chk("both_up", v, 32'h4);
        wr(3, 32'h4);
        tb_val[2:1] = 2'b00;
        idle(S + 2);
        rd(3, v); chk("both_down", v, 32'h6);
        wr(3, 32'hFFFF_FFFF);
        // clear and new edge in the same cycle
        tb_val[0] = 1'b0;
        idle(S + 2);
        tb_val[0] = 1'b1;
        idle(S + 2);
        tb_val[0] = 1'b0;
        idle(S + 2);
        tb_val[0] = 1'b1;
        idle(S);
        wr(3, 32'h1);
        rd(3, v); chk("collide", v, 32'h1);
        wr(3, 32'h1);
        rd(3, v); chk("collide_clr", v, 32'h0);
        // level mode through reset and arming
        tb_val = 30'h20;
        reset = 1'b1;
        bus.address = 3'd3;
        idle(2);
        reset = 1'b0;
        for (int c = 1; c <= S + 3; c++) begin
            tick();
            chk("arm_lvl", bus.readdata, (c == S + 3) ? 32'h2000_0020 : 32'h0);
        end
        wr(3, 32'h20);
        rd(3, v); chk("lvl_hold", v, 32'h2000_0020);
        tb_val = '0;
        idle(S + 2);
        wr(3, 32'hFFFF_FFFF);
        rd(3, v); chk("lvl_drop", v, 32'h2000_0000);
        // random traffic, pins and occasional resets
        for (int n = 0; n < 800; n++) begin
            bus.address    = 3'($urandom);
            bus.writedata  = $urandom;
            bus.chipselect = $urandom_range(0, 2) == 0;
            bus.write_n    = 1'($urandom_range(0, 1));
            tb_val         = tb_val ^ (W'($urandom) & W'($urandom) & W'($urandom));
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
